// File: rtl/ysyx_22051086_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ysyx_22051086_div_unit                                                   |
// | Iterative radix-2 restoring divider for RV64 M-extension div/rem ops.    |
// | Define DIV_EARLY_OUT_EN to skip iteration for trivial operand cases.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ysyx_22051086_div_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            div_valid,
   input  logic            divw,
   input  logic            div_signed,
   input  logic            flush,
   output logic            div_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int HALF = XLEN / 2;
   localparam int CW   = $clog2(XLEN);
   localparam logic [CW-1:0] c_CNT_D = CW'(XLEN - 1);
   localparam logic [CW-1:0] c_CNT_W = CW'(HALF - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_dvd, r_dvs, r_rem, r_quo;
   logic [XLEN-1:0] r_q_hold, r_r_hold;
   logic [CW-1:0]   r_cnt;
   logic            r_qneg, r_rneg, r_divw, r_dz;

   logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs;
   logic            w_sa, w_sb, w_dz;

   always_comb begin
      if (divw) begin
         w_a_ext = div_signed ? {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]}
                              : {{HALF{1'b0}}, dividend[HALF-1:0]};
         w_b_ext = div_signed ? {{HALF{divisor[HALF-1]}}, divisor[HALF-1:0]}
                              : {{HALF{1'b0}}, divisor[HALF-1:0]};
      end else begin
         w_a_ext = dividend;
         w_b_ext = divisor;
      end
      w_sa    = div_signed & w_a_ext[XLEN-1];
      w_sb    = div_signed & w_b_ext[XLEN-1];
      w_a_abs = w_sa ? -w_a_ext : w_a_ext;
      w_b_abs = w_sb ? -w_b_ext : w_b_ext;
   end

   assign w_dz = (w_b_ext == '0);

`ifdef DIV_EARLY_OUT_EN
   logic [XLEN-1:0] w_min;
   logic            w_ovf, w_early;
   assign w_min   = divw ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
   assign w_ovf   = div_signed && (w_a_ext == w_min) && (w_b_ext == '1);
   assign w_early = w_dz || w_ovf || (w_a_abs < w_b_abs);
`endif

   // Partial remainder needs one extra bit; its MSB doubles as the borrow flag.
   logic [XLEN:0] w_rem_sh, w_diff;
   logic          w_borrow;
   assign w_rem_sh = {r_rem, r_dvd[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};
   assign w_borrow = w_diff[XLEN];

   logic [XLEN-1:0] w_q_sgn, w_r_sgn, w_q_fix, w_r_fix;
   always_comb begin
      w_q_sgn = r_dz ? '1 : (r_qneg ? -r_quo : r_quo);
      w_r_sgn = r_rneg ? -r_rem : r_rem;
      if (r_divw) begin
         w_q_fix = {{HALF{w_q_sgn[HALF-1]}}, w_q_sgn[HALF-1:0]};
         w_r_fix = {{HALF{w_r_sgn[HALF-1]}}, w_r_sgn[HALF-1:0]};
      end else begin
         w_q_fix = w_q_sgn;
         w_r_fix = w_r_sgn;
      end
   end

   assign div_ready = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE) && !flush;
   assign quotient  = out_valid ? w_q_fix : r_q_hold;
   assign remainder = out_valid ? w_r_fix : r_r_hold;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_dvd    <= '0;
         r_dvs    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_q_hold <= '0;
         r_r_hold <= '0;
         r_cnt    <= '0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_divw   <= 1'b0;
         r_dz     <= 1'b0;
      end else if (flush) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (div_valid) begin
                  // W magnitudes sit in the upper half so the MSB-first shift sees them
                  r_dvd   <= divw ? {w_a_abs[HALF-1:0], {HALF{1'b0}}} : w_a_abs;
                  r_dvs   <= w_b_abs;
                  r_rem   <= '0;
                  r_quo   <= '0;
                  r_qneg  <= w_sa ^ w_sb;
                  r_rneg  <= w_sa;
                  r_divw  <= divw;
                  r_dz    <= w_dz;
                  r_cnt   <= divw ? c_CNT_W : c_CNT_D;
                  r_state <= S_CALC;
`ifdef DIV_EARLY_OUT_EN
                  if (w_early) begin
                     r_quo   <= w_ovf ? w_a_abs : '0;
                     r_rem   <= w_ovf ? '0 : w_a_abs;
                     r_state <= S_DONE;
                  end
`endif
               end
            end
            S_CALC: begin
               r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
               r_quo <= {r_quo[XLEN-2:0], ~w_borrow};
               r_rem <= w_borrow ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               r_q_hold <= w_q_fix;
               r_r_hold <= w_r_fix;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051086_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ysyx_22051086_div_unit                                                |
// | Randomised bench for the divider against an arithmetic reference model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ysyx_22051086_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] dividend = '0;
   logic [63:0] divisor = '0;
   logic        div_valid = 1'b0;
   logic        divw = 1'b0;
   logic        div_signed = 1'b0;
   logic        flush = 1'b0;
   logic        div_ready, out_valid;
   logic [63:0] quotient, remainder;

`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   ysyx_22051086_div_unit #(.XLEN(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .dividend   (dividend),
      .divisor    (divisor),
      .div_valid  (div_valid),
      .divw       (divw),
      .div_signed (div_signed),
      .flush      (flush),
      .div_ready  (div_ready),
      .out_valid  (out_valid),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [63:0] q;
      logic [63:0] r;
   } exp_t;

   exp_t        expq[$];
   int          busy_from = -10;
   int          busy_until = -10;
   logic [63:0] held_q = '0;
   logic [63:0] held_r = '0;
   logic [63:0] last_q = '0;
   logic [63:0] last_r = '0;
   int          last_vcyc = -1;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // M-extension semantics straight from the ISA rules, using native division.
   function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                 input bit w, input bit s,
                                 output logic [63:0] q, output logic [63:0] r,
                                 output bit early);
      logic [31:0] a32, b32, q32, r32, ma32, mb32;
      logic [63:0] ma, mb;
      a32 = a[31:0];
      b32 = b[31:0];
      if (w) begin
         ma32 = (s && a32[31]) ? -a32 : a32;
         mb32 = (s && b32[31]) ? -b32 : b32;
         if (b32 == 32'd0) begin
            q32 = 32'hFFFF_FFFF; r32 = a32; early = 1'b1;
         end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q32 = a32; r32 = 32'd0; early = 1'b1;
         end else begin
            if (s) begin
               q32 = 32'($signed(a32) / $signed(b32));
               r32 = 32'($signed(a32) % $signed(b32));
            end else begin
               q32 = a32 / b32;
               r32 = a32 % b32;
            end
            early = (ma32 < mb32);
         end
         q = {{32{q32[31]}}, q32};
         r = {{32{r32[31]}}, r32};
      end else begin
         ma = (s && a[63]) ? -a : a;
         mb = (s && b[63]) ? -b : b;
         if (b == 64'd0) begin
            q = '1; r = a; early = 1'b1;
         end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = '0; early = 1'b1;
         end else begin
            if (s) begin
               q = 64'($signed(a) / $signed(b));
               r = 64'($signed(a) % $signed(b));
            end else begin
               q = a / b;
               r = a % b;
            end
            early = (ma < mb);
         end
      end
   endfunction

   // Single compare process: every cycle out of reset, all outputs vs. model.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("div_ready", 64'(div_ready), 64'(!(cyc >= busy_from && cyc <= busy_until)));
         if (expq.size() > 0 && expq[0].due == cyc) begin
            chk("out_valid_strobe", 64'(out_valid), 64'd1);
            chk("quotient", quotient, expq[0].q);
            chk("remainder", remainder, expq[0].r);
            held_q    = expq[0].q;
            held_r    = expq[0].r;
            last_q    = quotient;
            last_r    = remainder;
            last_vcyc = cyc;
            void'(expq.pop_front());
         end else begin
            chk("out_valid_idle", 64'(out_valid), 64'd0);
            chk("quotient_held", quotient, held_q);
            chk("remainder_held", remainder, held_r);
         end
      end
   end

   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input bit w, input bit s,
                        input int abort_off, input bit abort_rst, output int acc);
      logic [63:0] eq, er;
      bit          early;
      int          lat;
      int          guard;
      guard = 0;
      while (!div_ready && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!div_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=0 expected=1 (t=%0t)", $time);
      end
      model(a, b, w, s, eq, er, early);
      lat = (EARLY && early) ? 0 : (w ? 32 : 64);
      dividend = a; divisor = b; divw = w; div_signed = s; div_valid = 1'b1;
      acc = cyc + 1;
      expq.push_back('{acc + lat, eq, er});
      busy_from  = acc;
      busy_until = acc + lat;
      @(posedge clk); #1;
      while (cyc < busy_until) begin
         // Requests while busy must be ignored and operands never re-sampled
         dividend   = {$urandom, $urandom};
         divisor    = {$urandom, $urandom};
         divw       = 1'($urandom_range(0, 1));
         div_signed = 1'($urandom_range(0, 1));
         div_valid  = 1'($urandom_range(0, 1));
         if (abort_off >= 0 && cyc == acc + abort_off) begin
            if (abort_rst) begin
               #2 rst = 1'b0;
               #1;
               chk("rst_div_ready", 64'(div_ready), 64'd1);
               chk("rst_out_valid", 64'(out_valid), 64'd0);
               chk("rst_quotient", quotient, 64'd0);
               chk("rst_remainder", remainder, 64'd0);
               expq.delete();
               busy_from  = -10;
               busy_until = -10;
               held_q     = '0;
               held_r     = '0;
               div_valid  = 1'b0;
               @(posedge clk); #1;
               rst = 1'b1;
            end else begin
               flush = 1'b1;
               void'(expq.pop_back());
               busy_until = cyc;
            end
         end
         @(posedge clk); #1;
         flush = 1'b0;
      end
      div_valid = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   initial begin
      int          acc;
      logic [63:0] a, b;
      bit          w, s;
      int          pat;

      #1;
      chk("reset_ready", 64'(div_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_quotient", quotient, 64'd0);
      chk("reset_remainder", remainder, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      do_op(64'd100, 64'd7, 1'b0, 1'b0, -1, 1'b0, acc);
      settle();
      chk("divu_100_7_q", last_q, 64'd14);
      chk("divu_100_7_r", last_r, 64'd2);
      chk("divu_100_7_lat", 64'(last_vcyc - acc), 64'd64);

      do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, -1, 1'b0, acc);
      settle();
      chk("div_m7_2_q", last_q, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("div_m7_2_r", last_r, 64'hFFFF_FFFF_FFFF_FFFF);

      do_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, -1, 1'b0, acc);
      settle();
      chk("divw_ovf_q", last_q, 64'hFFFF_FFFF_8000_0000);
      chk("divw_ovf_r", last_r, 64'd0);
      chk("divw_ovf_lat", 64'(last_vcyc - acc), EARLY ? 64'd0 : 64'd32);

      do_op(64'd5, 64'd0, 1'b0, 1'b0, -1, 1'b0, acc);
      settle();
      chk("remu_5_0_q", last_q, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("remu_5_0_r", last_r, 64'd5);

      do_op(64'h0000_0000_FFFF_FFFE, 64'd1, 1'b1, 1'b0, -1, 1'b0, acc);
      settle();
      chk("divuw_sext_q", last_q, 64'hFFFF_FFFF_FFFF_FFFE);

      // Flush part way through a full-length op
      do_op(64'h1234_5678_9ABC_DEF0, 64'd3, 1'b0, 1'b0, 9, 1'b0, acc);
      chk("flush_ready", 64'(div_ready), 64'd1);
      chk("flush_no_strobe", 64'(last_vcyc < acc), 64'd1);
      do_op(64'd9, 64'd3, 1'b0, 1'b0, -1, 1'b0, acc);
      settle();
      chk("after_flush_q", last_q, 64'd3);
      chk("after_flush_r", last_r, 64'd0);

      // A request colliding with flush while idle is dropped
      @(posedge clk); #1;
      dividend = 64'd50; divisor = 64'd5; div_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      div_valid = 1'b0; flush = 1'b0;
      chk("flush_drops_req", 64'(div_ready), 64'd1);

      // Asynchronous reset in the middle of iteration
      do_op(64'hFEDC_BA98_7654_3210, 64'd11, 1'b0, 1'b1, 20, 1'b1, acc);
      do_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, 1'b1, -1, 1'b0, acc);
      settle();
      chk("after_rst_q", last_q, 64'hFFFF_FFFF_FFFF_FFF2);
      chk("after_rst_r", last_r, 64'hFFFF_FFFF_FFFF_FFFE);

      for (int i = 0; i < 60; i++) begin
         w   = 1'($urandom_range(0, 1));
         s   = 1'($urandom_range(0, 1));
         pat = $urandom_range(0, 5);
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         case (pat)
            1: b = w ? {$urandom, 32'($urandom_range(1, 15))} : 64'($urandom_range(1, 15));
            2: b = w ? {$urandom, 32'd0} : 64'd0;
            3: begin
               s = 1'b1;
               a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
               b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
            end
            4: a = w ? {$urandom, 32'($urandom_range(0, 1000))} : 64'($urandom_range(0, 1000));
            5: begin
               a = -64'($urandom_range(1, 100000));
               b = w ? {$urandom, -32'($urandom_range(1, 300))} : -64'($urandom_range(1, 300));
            end
            default: ;
         endcase
         if ($urandom_range(0, 9) == 0) begin
            do_op(a, b, w, s, $urandom_range(0, 30), 1'b0, acc);
         end else begin
            do_op(a, b, w, s, -1, 1'b0, acc);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("all_results_seen", 64'(expq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
